// File: rtl/ball_engine.sv
// Ball sprite engine: draws a 2x2 ball, then erases, steps, bounces and redraws it every FRAMES_PER_MOVE frame ticks.
// Latency: a move request reaches ERASE two cycles after the triggering tick; a full erase/move/draw takes 9-10 cycles.
// Backpressure: enable is sampled only in IDLE/WAIT; a started erase/move/draw sequence always completes.
module ball_engine #(
  parameter int          SCREEN_W        = 160,
  parameter int          SCREEN_H        = 120,
  parameter int          FRAMES_PER_MOVE = 15,
  parameter int          PADDLE_Y        = 112,
  parameter int          PADDLE_W        = 16,
  parameter logic [2:0]  BALL_COLOUR     = 3'b111,
  parameter int          START_X         = 79,
  parameter int          START_Y         = 60
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [7:0] paddle_x,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic [7:0] ball_x,
  output logic [6:0] ball_y,
  output logic       ball_lost
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ERASE,
    S_MOVE,
    S_LOST,
    S_DRAW
  } state_t;

  localparam logic [7:0] X_MAX      = 8'(SCREEN_W - 2);
  localparam logic [6:0] Y_MAX      = 7'(SCREEN_H - 2);
  localparam logic [8:0] PAD_ROW    = 9'(PADDLE_Y);
  localparam logic [8:0] PAD_W9     = 9'(PADDLE_W);
  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_MOVE - 1);
  localparam logic [7:0] START_X8   = 8'(START_X);
  localparam logic [6:0] START_Y7   = 7'(START_Y);

  state_t     state, state_nxt;
  logic [1:0] pix_cnt;
  logic [7:0] frame_cnt;
  logic       move_req;
  logic       dx, dy;
  logic       frame_wrap;
  logic       hit_right, hit_left, hit_top, hit_paddle, hit_bottom;

  assign frame_wrap = enable && frame_tick && (frame_cnt == FRAME_LAST);

  // Paddle test is done in 9 bits so paddle_x + PADDLE_W near 255 cannot wrap.
  assign hit_right  = dx && (ball_x == X_MAX);
  assign hit_left   = !dx && (ball_x == 8'd0);
  assign hit_top    = !dy && (ball_y == 7'd0);
  assign hit_paddle = dy && (({2'b00, ball_y} + 9'd2) == PAD_ROW)
                      && (({1'b0, ball_x} + 9'd2) > {1'b0, paddle_x})
                      && ({1'b0, ball_x} < ({1'b0, paddle_x} + PAD_W9));
  assign hit_bottom = dy && !hit_paddle && (ball_y == Y_MAX);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode; enable only matters while parked in IDLE or WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable) state_nxt = S_DRAW;
      S_WAIT:  if (move_req && enable) state_nxt = S_ERASE;
      S_ERASE: if (pix_cnt == 2'd3) state_nxt = S_MOVE;
      S_MOVE:  state_nxt = hit_bottom ? S_LOST : S_DRAW;
      S_LOST:  state_nxt = S_DRAW;
      S_DRAW:  if (pix_cnt == 2'd3) state_nxt = S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pixel counter walks the four ball pixels in ERASE and DRAW, idles at 0 elsewhere.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                 pix_cnt <= 2'd0;
    else if (state == S_ERASE || state == S_DRAW) pix_cnt <= pix_cnt + 2'd1;
    else                                          pix_cnt <= 2'd0;
  end

  // Frame divider; a new request wins over the clear on ERASE entry so none is lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt <= 8'd0;
      move_req  <= 1'b0;
    end else begin
      if (enable && frame_tick) frame_cnt <= frame_wrap ? 8'd0 : frame_cnt + 8'd1;
      if (frame_wrap)                                     move_req <= 1'b1;
      else if (state == S_WAIT && state_nxt == S_ERASE)   move_req <= 1'b0;
    end
  end

  // Ball position and direction: stepped in MOVE (x and y independently), re-served in LOST.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ball_x <= START_X8;
      ball_y <= START_Y7;
      dx     <= 1'b1;
      dy     <= 1'b0;
    end else if (state == S_LOST) begin
      ball_x <= START_X8;
      ball_y <= START_Y7;
      dx     <= 1'b1;
      dy     <= 1'b0;
    end else if (state == S_MOVE && !hit_bottom) begin
      if (hit_right) begin
        dx     <= 1'b0;
        ball_x <= ball_x - 8'd1;
      end else if (hit_left) begin
        dx     <= 1'b1;
        ball_x <= ball_x + 8'd1;
      end else begin
        ball_x <= dx ? ball_x + 8'd1 : ball_x - 8'd1;
      end
      if (hit_top) begin
        dy     <= 1'b1;
        ball_y <= ball_y + 7'd1;
      end else if (hit_paddle) begin
        dy     <= 1'b0;
        ball_y <= ball_y - 7'd1;
      end else begin
        ball_y <= dy ? ball_y + 7'd1 : ball_y - 7'd1;
      end
    end
  end

  // Moore output decode; pixel bus is quiet outside ERASE and DRAW.
  always_comb begin
    x         = 8'd0;
    y         = 7'd0;
    colour    = 3'b000;
    plot      = 1'b0;
    busy      = 1'b0;
    ball_lost = 1'b0;
    case (state)
      S_ERASE: begin
        x    = ball_x + {7'd0, pix_cnt[0]};
        y    = ball_y + {6'd0, pix_cnt[1]};
        plot = 1'b1;
        busy = 1'b1;
      end
      S_DRAW: begin
        x      = ball_x + {7'd0, pix_cnt[0]};
        y      = ball_y + {6'd0, pix_cnt[1]};
        colour = BALL_COLOUR;
        plot   = 1'b1;
        busy   = 1'b1;
      end
      S_MOVE: busy = 1'b1;
      S_LOST: begin
        busy      = 1'b1;
        ball_lost = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine with a 141-pixel-wide court so the ball from (79,60) reaches the (139,0) corner.
// Ball path: up-right to (139,0), corner bounce, down-left to (29,110) where the paddle cases are exercised.
// Plots are logged on the falling edge; all checks go through chk().
module tb_ball_engine;

  logic       clk        = 1'b0;
  logic       resetn     = 1'b1;
  logic       enable     = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] paddle_x   = 8'd200;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       ball_lost;

  int checks = 0;
  int errors = 0;
  int np     = 0;
  int nlost  = 0;
  logic [17:0] plog [16];

  ball_engine #(.SCREEN_W(141)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .frame_tick (frame_tick),
    .paddle_x   (paddle_x),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .ball_lost  (ball_lost)
  );

  always #5 clk = ~clk;

  // Log every plotted pixel (circular, last 16) and count loss pulses.
  always @(negedge clk) begin
    if (plot) begin
      plog[np % 16] = {x, y, colour};
      np++;
    end
    if (ball_lost) nlost++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc(1);
    end
    frame_tick = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int k = 0;
    while (busy !== lvl && k < 60) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(busy), 32'(lvl));
  endtask

  task automatic run_move();
    ticks(15);
    wait_busy(1'b1, "seq_start");
    wait_busy(1'b0, "seq_end");
  endtask

  task automatic run_moves(input int n);
    repeat (n) run_move();
  endtask

  // Four logged pixels starting at absolute plot index b form the square at (bx,by).
  task automatic chk_sq(input string tag, input int b, input int bx, input int by, input int col);
    for (int i = 0; i < 4; i++) begin
      logic [17:0] e;
      e = {8'(bx + (i % 2)), 7'(by + (i / 2)), 3'(col)};
      chk(tag, 32'(plog[(b + i) % 16]), 32'(e));
    end
  endtask

  task automatic chk_ball(input string tag, input int bx, input int by);
    chk({tag, "_x"}, 32'(ball_x), 32'(bx));
    chk({tag, "_y"}, 32'(ball_y), 32'(by));
  endtask

  initial begin
    int b;
    int l;
    int k;

    // Reset state.
    #2 resetn = 1'b0;
    cyc(2);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_xy", 32'({x, y, colour}), 32'd0);
    chk("rst_lost", 32'(ball_lost), 32'd0);
    chk_ball("rst_ball", 79, 60);

    // Initial draw.
    b = np;
    resetn = 1'b1;
    enable = 1'b1;
    cyc(1);
    chk("init_draw_busy", 32'(busy), 32'd1);
    cyc(4);
    chk("init_wait_busy", 32'(busy), 32'd0);
    chk("init_nplots", 32'(np - b), 32'd4);
    chk_sq("init_sq", b, 79, 60, 7);

    // Frame divider: 14 ticks do nothing, the 15th starts a move with exact timing.
    b = np;
    ticks(14);
    cyc(5);
    chk("ticks14_noplot", 32'(np - b), 32'd0);
    ticks(1);
    chk("t1_plot", 32'(plot), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    cyc(1);
    chk("t2_erase", 32'({plot, x, y, colour}), 32'({1'b1, 8'd79, 7'd60, 3'd0}));
    cyc(4);
    chk("t6_move_plot", 32'(plot), 32'd0);
    chk("t6_move_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("t7_draw", 32'({plot, x, y, colour}), 32'({1'b1, 8'd80, 7'd59, 3'd7}));
    cyc(4);
    chk("t11_wait", 32'(busy), 32'd0);
    chk("move1_nplots", 32'(np - b), 32'd8);
    chk_sq("move1_erase", b, 79, 60, 0);
    chk_sq("move1_draw", b + 4, 80, 59, 7);
    chk_ball("move1", 80, 59);

    // Up-right to the corner, then corner bounce flips both directions.
    run_moves(59);
    chk_ball("corner_pre", 139, 0);
    run_move();
    chk_ball("corner", 138, 1);
    run_move();
    chk_ball("corner_dir", 137, 2);

    // Down-left to the paddle row; paddle_x == ball_x+2 just misses.
    run_moves(108);
    chk_ball("pad_row", 29, 110);
    paddle_x = 8'd31;
    run_move();
    chk_ball("pad_edge_miss", 28, 111);
    paddle_x = 8'd200;
    run_moves(7);
    chk_ball("bottom_row", 21, 118);

    // Loss: one pulse, erase old square, redraw at start.
    b = np;
    l = nlost;
    run_move();
    chk("lost_pulses", 32'(nlost - l), 32'd1);
    chk("lost_nplots", 32'(np - b), 32'd8);
    chk_sq("lost_erase", b, 21, 118, 0);
    chk_sq("lost_draw", b + 4, 79, 60, 7);
    chk_ball("lost_pos", 79, 60);
    run_move();
    chk_ball("lost_dir", 80, 59);

    // Second pass: paddle under the ball bounces it back up.
    run_moves(169);
    chk_ball("pad_row2", 29, 110);
    paddle_x = 8'd20;
    run_move();
    chk_ball("pad_bounce", 28, 109);
    paddle_x = 8'd200;
    run_move();
    chk_ball("pad_after", 27, 108);

    // Drop enable during ERASE: sequence completes, then nothing more.
    b = np;
    ticks(15);
    wait_busy(1'b1, "en_erase");
    enable = 1'b0;
    wait_busy(1'b0, "en_done");
    chk("en_nplots", 32'(np - b), 32'd8);
    chk_ball("en_pos", 26, 107);
    b = np;
    ticks(45);
    cyc(20);
    chk("en_hold_noplot", 32'(np - b), 32'd0);
    chk("en_hold_busy", 32'(busy), 32'd0);

    // Reset in the middle of DRAW.
    enable = 1'b1;
    ticks(15);
    k = 0;
    while (!(plot === 1'b1 && colour === 3'd7) && k < 60) begin
      cyc(1);
      k++;
    end
    chk("reach_draw", 32'(plot), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_plot", 32'(plot), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_x", 32'(x), 32'd0);
    chk_ball("midrst_ball", 79, 60);
    cyc(1);
    resetn = 1'b1;
    b = np;
    cyc(1);
    chk("rst_redraw", 32'({plot, x, y, colour}), 32'({1'b1, 8'd79, 7'd60, 3'd7}));
    cyc(4);
    chk("rst_redraw_n", 32'(np - b), 32'd4);
    chk("rst_redraw_wait", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
